dlfloat_mul_sched: RTL and testbench
====================================

# dlfloat_mul_sched

Round-robin scheduler that shares one DLFloat16 multiplier (`dlfloat_mult`, registered, 1-cycle latency, no reset) between `NUM_REQ` requesters. Accepts operand pairs over per-requester valid/ready handshakes and issues at most one product per cycle. Tracks in-flight products with a tag pipeline and returns results, tagged with requester ID, through a credit-protected response FIFO. Sits between the compute lanes and the single multiplier instance in the DL-float datapath.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `MUL_LAT`, 1, cycles from operands on `mul_a`/`mul_b` to valid `mul_c`
- `RSP_DEPTH`, 4, response FIFO entries (power of two, ≥ 2)

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  operand pair valid, one bit per requester
- `req_ready`  out  NUM_REQ  one-hot grant/accept; at most one bit set
- `req_a`, `req_b`  in  NUM_REQ*16  packed operands; requester i uses bits [16i+15:16i]
- `mul_a`, `mul_b`  out  16  registered operands to the multiplier
- `mul_c`  in  16  multiplier result
- `rsp_valid`  out  1  FIFO head valid
- `rsp_ready`  in  1  consumer accepts head
- `rsp_c`  out  16  product
- `rsp_id`  out  $clog2(NUM_REQ)  originating requester
- `busy`  out  1  any product in flight or buffered

## Operation
- Credit check: `issue_ok = (fifo_count + inflight) < RSP_DEPTH`, using registered values. A same-cycle FIFO pop does not free a credit until the next cycle.
- Arbitration: round-robin over `req_valid`. The search starts at `last_grant+1` modulo `NUM_REQ`. `last_grant` resets to `NUM_REQ-1`, so requester 0 wins first.
- When `issue_ok` and any `req_valid` is set, assert `req_ready[g]` for the winner g only. `req_ready` is combinational from `req_valid`, `last_grant` and the credit state. Transfer occurs on `req_valid[g] & req_ready[g]`.
- On transfer:
  - latch `req_a[g]`/`req_b[g]` into `mul_a`/`mul_b`
  - update `last_grant <= g`
  - push {valid=1, id=g} into the tag pipe
- With no transfer, `mul_a`/`mul_b` hold their values and a valid=0 entry is pushed.
- Tag pipe: `MUL_LAT+1` stages. Stage 0 aligns with `mul_a`/`mul_b`; the last stage aligns with valid `mul_c`. When the last stage is valid, write {`mul_c`, id} to the FIFO.
- `inflight` counts valid tag-pipe stages. It increments on transfer, decrements when the last stage is valid, and is unchanged when both occur.
- FIFO pop on `rsp_valid & rsp_ready`. Simultaneous push and pop keeps `fifo_count`.
- Credit accounting guarantees no FIFO overflow, so pushes are never dropped. Overflow is an assertion failure.
- `busy = (inflight != 0) | (fifo_count != 0)`.
- Requester ordering: results return in issue order. No reordering across requesters.
- Arithmetic: the scheduler never inspects operand or result bits. Special-value handling (zero, subnormal flush) belongs to the multiplier.

## Timing
- Reset values:
  - `req_ready=0` (no grant during `rst`)
  - `mul_a=mul_b=16'h0000`
  - `rsp_valid=0`, `rsp_c=0`, `rsp_id=0`, `busy=0`
  - all tag-pipe valids 0, `inflight=0`, `fifo_count=0`, `last_grant=NUM_REQ-1`
- Latency (MUL_LAT=1, empty FIFO): transfer at edge E0 → `mul_a` valid after E0 → `mul_c` valid after E1 → FIFO write at E2 → `rsp_valid=1` after E2. Total: 3 cycles from transfer to `rsp_valid`.
- Throughput: one transfer per cycle while credits remain. With `rsp_ready` held high and `RSP_DEPTH` ≥ `MUL_LAT+3`, sustained rate is 1 per cycle.
- Mid-operation reset: in-flight tags and FIFO contents are discarded. The multiplier's unreset output is ignored because all tag valids are 0. The first grant after reset goes to requester 0.
- Requesters may drop `req_valid` without a transfer. No request stickiness is required.

## Structure
- Shared package `dlfloat_pkg`:
  - `DLF_W=16`, `DLF_EXP_W=6`, `DLF_MAN_W=9`, `DLF_BIAS=31`
  - `typedef logic [15:0] dlf_t`
  - tag struct {valid, id}
- Sub-module `dlfloat_rsp_fifo`: synchronous FIFO, depth `RSP_DEPTH`, width 16 + id. Provides push, pop, count, head outputs and the same `clk`/`rst`.
- The round-robin select is a function inside the scheduler, not a separate module.
- `dlfloat_mult` is instantiated outside the scheduler, at the parent level.

## Test plan
- Single request: req0 a=0x3F00 (1.5), b=0x4000 (2.0) → after 3 cycles `rsp_valid=1`, `rsp_c=0x4100`, `rsp_id=0`; `busy` returns to 0 the cycle after pop.
- All four requesters held valid, each with a=0x4000, b=0x4000, `rsp_ready=1` → grants in order 0,1,2,3,0,… one per cycle; every `rsp_c=0x4200`; `rsp_id` sequence matches grant order.
- `rsp_ready=0`, req1 held valid with 1.0×1.0 (0x3E00) → exactly `RSP_DEPTH`=4 transfers, then `req_ready=0`. Raising `rsp_ready` drains 4 results of 0x3E00 and grants resume one cycle after the first pop.
- FIFO full with a simultaneous pop and a pending request → no grant that cycle, grant the next cycle; no overflow assertion.
- Assert `rst` for 1 cycle with 2 products in flight → `rsp_valid` stays 0 afterward, `inflight=0`, and the next grant goes to requester 0.
- Zero operand: req2 a=0x0000, b=0x4000 → `rsp_c=0x0000`, `rsp_id=2`.

Source files
------------

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 datapath types and constants.
package dlfloat_pkg;

  localparam int unsigned DLF_W     = 16;
  localparam int unsigned DLF_EXP_W = 6;
  localparam int unsigned DLF_MAN_W = 9;
  localparam int unsigned DLF_BIAS  = 31;

  // Widest requester id supported by the scheduler (NUM_REQ up to 8).
  localparam int unsigned DLF_ID_W  = 3;

  typedef logic [15:0] dlf_t;

  // One tag-pipe stage: tracks whether the multiplier slot holds a live product.
  typedef struct packed {
    logic                valid;
    logic [DLF_ID_W-1:0] id;
  } dlf_tag_t;

  // Response payload held in the response FIFO.
  typedef struct packed {
    dlf_t                c;
    logic [DLF_ID_W-1:0] id;
  } dlf_rsp_t;

endpackage

// File: rtl/dlfloat_rsp_fifo.sv
// Synchronous response FIFO carrying {product, requester id}.
module dlfloat_rsp_fifo
  import dlfloat_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  dlf_rsp_t                 push_data,
  input  logic                     pop,
  output dlf_rsp_t                 head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  dlf_rsp_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_eff;

  assign head_valid = (count != '0);
  assign pop_eff    = pop && head_valid;
  assign head       = head_valid ? mem[rd_ptr] : '0;

  // Storage array; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop_eff})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Credit accounting upstream must never let a push land on a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop_eff && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/dlfloat_mul_sched.sv
// Round-robin scheduler sharing one registered DLFloat16 multiplier between
// NUM_REQ requesters, with credit-protected, id-tagged in-order responses.
module dlfloat_mul_sched
  import dlfloat_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MUL_LAT   = 1,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*16-1:0]        req_a,
  input  logic [NUM_REQ*16-1:0]        req_b,
  output logic [15:0]                  mul_a,
  output logic [15:0]                  mul_b,
  input  logic [15:0]                  mul_c,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [15:0]                  rsp_c,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic                         busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

  logic [ID_W-1:0]     last_grant;
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic                issue_ok;
  logic [ID_W:0]       pick;
  logic [ID_W-1:0]     grant_idx;
  logic                xfer;
  dlf_t                sel_a;
  dlf_t                sel_b;
  dlf_tag_t [MUL_LAT:0] tag_pipe;
  dlf_tag_t            tag_last;
  dlf_rsp_t            push_data;
  dlf_rsp_t            rsp_head;
  logic                pop;
  logic                unused_id_bits;

  // Round-robin search starting one past the previous winner; MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] res;
    res = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned cand;
      cand = (32'(last) + k) % NUM_REQ;
      if (!res[ID_W] && valid[ID_W'(cand)]) begin
        res = {1'b1, ID_W'(cand)};
      end
    end
    return res;
  endfunction

  // Credits use registered state only, so a pop frees its slot one cycle later.
  assign issue_ok = (32'(fifo_count) + 32'(inflight)) < RSP_DEPTH;

  // Combinational grant: one-hot to the round-robin winner while credits remain.
  always_comb begin
    pick      = rr_pick(req_valid, last_grant);
    grant_idx = pick[ID_W-1:0];
    req_ready = '0;
    if (!rst && issue_ok && pick[ID_W]) begin
      req_ready[grant_idx] = 1'b1;
    end
    xfer  = |(req_valid & req_ready);
    sel_a = req_a[DLF_W*32'(grant_idx) +: DLF_W];
    sel_b = req_b[DLF_W*32'(grant_idx) +: DLF_W];
  end

  // Operand registers feeding the multiplier and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (xfer) begin
      mul_a      <= sel_a;
      mul_b      <= sel_b;
      last_grant <= grant_idx;
    end
  end

  // Tag pipe: stage 0 aligns with mul_a/mul_b, last stage with a valid mul_c.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= '{valid: xfer, id: DLF_ID_W'(grant_idx)};
      for (int unsigned i = 1; i <= MUL_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tag_last = tag_pipe[MUL_LAT];

  // Count of live products inside the multiplier pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({xfer, tag_last.valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign push_data = '{c: mul_c, id: tag_last.id};
  assign pop       = rsp_valid && rsp_ready;

  dlfloat_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (tag_last.valid),
    .push_data  (push_data),
    .pop        (pop),
    .head       (rsp_head),
    .head_valid (rsp_valid),
    .count      (fifo_count)
  );

  // Response head; id bits above ID_W are always zero for smaller NUM_REQ.
  assign rsp_c          = rsp_head.c;
  assign rsp_id         = ID_W'(rsp_head.id);
  assign unused_id_bits = ^rsp_head.id;

  assign busy = (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_dlfloat_mul_sched.sv
// Directed bench for dlfloat_mul_sched with a behavioural 1-cycle DLFloat16 multiplier.
module tb_dlfloat_mul_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_c;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_c;
  logic [1:0]  rsp_id;
  logic        busy;

  int checks;
  int failures;

  dlfloat_mul_sched #(
    .NUM_REQ   (4),
    .MUL_LAT   (1),
    .RSP_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating DLFloat16 multiply (1/6/9, bias 31); zero exponent flushes to zero.
  function automatic logic [15:0] dlf_mul(input logic [15:0] a, input logic [15:0] b);
    logic [19:0] p;
    logic [8:0]  m;
    int          e;
    if (a[14:9] == 6'd0 || b[14:9] == 6'd0) return {a[15] ^ b[15], 15'h0};
    p = 20'({1'b1, a[8:0]}) * 20'({1'b1, b[8:0]});
    e = int'(a[14:9]) + int'(b[14:9]) - 31;
    if (p[19]) begin
      m = p[18:10];
      e = e + 1;
    end else begin
      m = p[17:9];
    end
    return {a[15] ^ b[15], 6'(e), m};
  endfunction

  // Multiplier stand-in: registered, one cycle of latency, no reset.
  always @(posedge clk) mul_c <= dlf_mul(mul_a, mul_b);

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (mul_a !== 16'h0000 || mul_b !== 16'h0000) begin failures++; $display("FAIL reset_mul got=%h/%h exp=0000/0000", mul_a, mul_b); end
    checks++; if (rsp_valid !== 1'b0 || rsp_c !== 16'h0000 || rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp got=%b/%h/%0d exp=0/0000/0", rsp_valid, rsp_c, rsp_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    req_valid = 4'h0;
    rst       = 1'b0;
  endtask

  task automatic test_round_robin();
    int got;
    got = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 16'h4000, 16'h4000);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        checks++; if (rsp_c !== 16'h4200) begin failures++; $display("FAIL rr_rsp_c got=%h exp=4200", rsp_c); end
        checks++; if (rsp_id !== 2'(got % 4)) begin failures++; $display("FAIL rr_rsp_id got=%0d exp=%0d", rsp_id, got % 4); end
        got++;
      end
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) begin
        checks++; if (req_ready !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
      end
    end
    checks++; if (got != 8) begin failures++; $display("FAIL rr_count got=%0d exp=8", got); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle_busy got=%b exp=0", busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, 16'h3F00, 16'h4000);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    checks++; if (mul_a !== 16'h3F00 || mul_b !== 16'h4000) begin failures++; $display("FAIL single_mul got=%h/%h exp=3f00/4000", mul_a, mul_b); end
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL single_e0 busy/rsp_valid got=%b/%b exp=1/0", busy, rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_e1_rsp_valid got=%b exp=0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_c !== 16'h4100 || rsp_id !== 2'd0) begin failures++; $display("FAIL single_rsp got=%b/%h/%0d exp=1/4100/0", rsp_valid, rsp_c, rsp_id); end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_after_pop rsp_valid/busy got=%b/%b exp=0/0", rsp_valid, busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_credit();
    int xfers;
    int got;
    xfers = 0;
    got   = 0;
    rsp_ready = 1'b0;
    set_req(1, 16'h3E00, 16'h3E00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid = 4'b0010;
      #1;
      if (req_ready[1] === 1'b1) xfers++;
    end
    checks++; if (xfers != 4) begin failures++; $display("FAIL credit_xfers got=%0d exp=4", xfers); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL credit_block got=%b exp=0000", req_ready); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        checks++; if (rsp_c !== 16'h3E00 || rsp_id !== 2'd1) begin failures++; $display("FAIL credit_rsp got=%h/%0d exp=3e00/1", rsp_c, rsp_id); end
        got++;
      end
      if (k == 0) begin
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL full_pop_no_grant got=%b exp=0000", req_ready); end
      end else if (k == 1) begin
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL grant_resume got=%b exp=0010", req_ready); end
      end else if (k == 2) begin
        req_valid = 4'b0000;
      end
    end
    checks++; if (got != 5) begin failures++; $display("FAIL credit_drain_count got=%0d exp=5", got); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL credit_idle_busy got=%b exp=0", busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    set_req(2, 16'h4000, 16'h4000);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL midrst_grant0 got=%b exp=0100", req_ready); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL midrst_grant1 got=%b exp=0100", req_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_inflight_busy got=%b exp=1", busy); end
    rst       = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (mul_a !== 16'h0000) begin failures++; $display("FAIL midrst_mul_a got=%h exp=0000", mul_a); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_quiet k=%0d rsp_valid/busy got=%b/%b exp=0/0", k, rsp_valid, busy); end
      @(negedge clk);
    end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_first_grant got=%b exp=0001", req_ready); end
    req_valid = 4'h0;
  endtask

  task automatic test_zero();
    bit seen;
    seen = 1'b0;
    rsp_ready = 1'b1;
    set_req(2, 16'h0000, 16'h4000);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL zero_grant got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        checks++; if (rsp_c !== 16'h0000 || rsp_id !== 2'd2) begin failures++; $display("FAIL zero_rsp got=%h/%0d exp=0000/2", rsp_c, rsp_id); end
      end
    end
    if (!seen) begin
      checks++; failures++; $display("FAIL zero_timeout got=no_response exp=response");
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_credit();
    test_mid_reset();
    test_zero();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
